branch_predictor: RTL

Parametrised branch resolve-and-predict unit for the pipelined MIPS core. It evaluates MIPS branch and jump instructions (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, J, JAL) with delay-slot semantics. It keeps a direct-mapped branch target buffer with saturating direction counters, answers fetch-stage lookups one cycle later, and reports mispredictions plus a redirect PC to the fetch stage.

---
 rtl/branch_predictor.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Branch resolve-and-predict unit: resolves MIPS branches/jumps with delay-slot semantics and
// keeps a direct-mapped BTB with saturating direction counters for fetch-stage prediction.
module branch_predictor #(
   parameter int unsigned BTB_DEPTH = 64,
   parameter int unsigned CTR_WIDTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        lookup_valid,
   input  logic [31:0] lookup_pc,
   output logic        pred_valid,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        resolve_valid,
   input  logic [31:0] resolve_pc,
   input  logic [31:0] resolve_instr,
   input  logic [31:0] resolve_rs,
   input  logic [31:0] resolve_rt,
   input  logic        resolve_pred_taken,
   input  logic [31:0] resolve_pred_target,
   output logic        res_valid,
   output logic        res_taken,
   output logic [31:0] res_new_pc,
   output logic        res_mispredict,
   output logic        res_link,
   output logic [31:0] res_link_value,
   output logic        res_ri,
   output logic [31:0] mispredict_count
);

   localparam int unsigned IDX   = $clog2(BTB_DEPTH);
   localparam int unsigned TAG_W = 30 - IDX;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);
   localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);

   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;

   logic [BTB_DEPTH-1:0] btb_valid;
   logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
   logic [31:0]          btb_target [BTB_DEPTH];
   logic [CTR_WIDTH-1:0] btb_ctr    [BTB_DEPTH];

   // Lookup path: reads current contents, so a same-cycle update is not yet visible.
   logic [IDX-1:0] lk_idx;
   logic           lk_hit;
   logic           lk_taken;
   logic [31:0]    lk_target;

   always_comb begin
      lk_idx    = lookup_pc[IDX+1:2];
      lk_hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == lookup_pc[31:IDX+2]);
      lk_taken  = lk_hit && btb_ctr[lk_idx][CTR_WIDTH-1];
      lk_target = lk_taken ? btb_target[lk_idx] : lookup_pc + 32'd8;
   end

   // Resolve decode
   logic [5:0]  opcode;
   logic [4:0]  rt_sel;
   logic [31:0] imm_ext;
   logic [31:0] pc_plus8;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic        dec_taken;
   logic [31:0] dec_target;
   logic        dec_link;
   logic        dec_ri;
   logic        dec_jump;
   logic        dec_mispredict;
   logic [31:0] dec_new_pc;

   always_comb begin
      opcode     = resolve_instr[31:26];
      rt_sel     = resolve_instr[20:16];
      imm_ext    = {{14{resolve_instr[15]}}, resolve_instr[15:0], 2'b00};
      pc_plus8   = resolve_pc + 32'd8;
      br_target  = resolve_pc + 32'd4 + imm_ext;
      j_target   = {resolve_pc[31:28], resolve_instr[25:0], 2'b00};
      dec_taken  = 1'b0;
      dec_target = br_target;
      dec_link   = 1'b0;
      dec_ri     = 1'b0;
      dec_jump   = 1'b0;
      case (opcode)
         OP_REGIMM: begin
            case (rt_sel)
               5'h00: dec_taken = $signed(resolve_rs) < 0;
               5'h01: dec_taken = $signed(resolve_rs) >= 0;
               5'h10: begin
                  dec_taken = $signed(resolve_rs) < 0;
                  dec_link  = 1'b1;
               end
               5'h11: begin
                  dec_taken = $signed(resolve_rs) >= 0;
                  dec_link  = 1'b1;
               end
               default: dec_ri = 1'b1;
            endcase
         end
         OP_J: begin
            dec_taken  = 1'b1;
            dec_jump   = 1'b1;
            dec_target = j_target;
         end
         OP_JAL: begin
            dec_taken  = 1'b1;
            dec_jump   = 1'b1;
            dec_link   = 1'b1;
            dec_target = j_target;
         end
         OP_BEQ:  dec_taken = resolve_rs == resolve_rt;
         OP_BNE:  dec_taken = resolve_rs != resolve_rt;
         OP_BLEZ: dec_taken = $signed(resolve_rs) <= 0;
         OP_BGTZ: dec_taken = $signed(resolve_rs) > 0;
         default: dec_ri = 1'b1;
      endcase
      dec_mispredict = !dec_ri && ((dec_taken != resolve_pred_taken) ||
                                   (dec_taken && (dec_target != resolve_pred_target)));
      dec_new_pc     = (!dec_ri && dec_taken) ? dec_target : pc_plus8;
   end

   // BTB update
   logic [IDX-1:0]       up_idx;
   logic                 up_hit;
   logic                 up_en;
   logic [CTR_WIDTH-1:0] up_ctr;
   logic [31:0]          up_target;

   always_comb begin
      up_idx    = resolve_pc[IDX+1:2];
      up_hit    = btb_valid[up_idx] && (btb_tag[up_idx] == resolve_pc[31:IDX+2]);
      up_en     = resolve_valid && !dec_ri && (up_hit || dec_taken);
      up_target = dec_target;
      up_ctr    = dec_jump ? CTR_MAX : CTR_WEAK;
      if (up_hit) begin
         if (dec_taken) begin
            up_ctr = (btb_ctr[up_idx] == CTR_MAX) ? CTR_MAX : btb_ctr[up_idx] + CTR_ONE;
         end else begin
            up_ctr    = (btb_ctr[up_idx] == '0) ? '0 : btb_ctr[up_idx] - CTR_ONE;
            up_target = btb_target[up_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         btb_valid <= '0;
      end else if (up_en) begin
         btb_valid[up_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (up_en) begin
         btb_tag[up_idx]    <= resolve_pc[31:IDX+2];
         btb_target[up_idx] <= up_target;
         btb_ctr[up_idx]    <= up_ctr;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pred_valid  <= 1'b0;
         pred_hit    <= 1'b0;
         pred_taken  <= 1'b0;
         pred_target <= '0;
      end else begin
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            pred_hit    <= lk_hit;
            pred_taken  <= lk_taken;
            pred_target <= lk_target;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         res_valid      <= 1'b0;
         res_taken      <= 1'b0;
         res_new_pc     <= '0;
         res_mispredict <= 1'b0;
         res_link       <= 1'b0;
         res_link_value <= '0;
         res_ri         <= 1'b0;
      end else begin
         res_valid <= resolve_valid;
         if (resolve_valid) begin
            res_taken      <= dec_taken && !dec_ri;
            res_new_pc     <= dec_new_pc;
            res_mispredict <= dec_mispredict;
            res_link       <= dec_link && !dec_ri;
            res_link_value <= pc_plus8;
            res_ri         <= dec_ri;
         end
      end
   end

   logic [31:0] mispredict_count_q;
   logic [31:0] mispredict_count_d;

   always_comb begin
      mispredict_count_d = mispredict_count_q + {31'b0, resolve_valid && dec_mispredict};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mispredict_count_q <= '0;
      end else begin
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign mispredict_count = mispredict_count_q;

endmodule
